// File: rtl/adxl_spi_responder.sv
// rtl/adxl_spi_responder.sv - SPI mode-0 accelerometer-side responder with byte register file
// Optional macro ADXL_RESP_WRITE_EN enables 0x0A write transactions.
module adxl_spi_responder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_i,
    input  logic              mosi_i,
    input  logic              ncs_i,
    output logic              miso_o,
    output logic              miso_oe,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [7:0] CMD_READ = 8'h0B;
`ifdef ADXL_RESP_WRITE_EN
    localparam logic [7:0] CMD_WRITE = 8'h0A;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_READ, S_WRITE, S_IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]        sclk_sync;
    logic [2:0]        ncs_sync;
    logic [1:0]        mosi_sync;
    logic              rise, fall, ncs_s, ncs_fall, mosi_s;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx;
    logic [7:0]        rx_byte;
    logic              byte_done;
    logic [ADDR_W-1:0] ptr, ptr_inc;
    logic [7:0]        shift;
    logic              skip_fall;
    logic              op_write;
    logic [7:0]        regs [DEPTH];

    function automatic logic [7:0] reset_val(input int idx);
        case (idx)
            0:       return 8'hAD;
            1:       return 8'h1D;
            2:       return 8'hF2;
            default: return 8'h00;
        endcase
    endfunction

    // Two sync flops per input; bit 2 of sclk/ncs is the edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 3'b000;
            ncs_sync  <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk_i};
            ncs_sync  <= {ncs_sync[1:0], ncs_i};
            mosi_sync <= {mosi_sync[0], mosi_i};
        end
    end

    assign rise     = sclk_sync[1] & ~sclk_sync[2];
    assign fall     = ~sclk_sync[1] & sclk_sync[2];
    assign ncs_s    = ncs_sync[1];
    assign ncs_fall = ~ncs_sync[1] & ncs_sync[2];
    assign mosi_s   = mosi_sync[1];
    assign busy     = ~ncs_s;

    assign rx_byte   = {rx, mosi_s};
    assign byte_done = rise && (bit_cnt == 3'd7) && !ncs_s && (state != S_IDLE);
    assign ptr_inc   = ptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= 3'd0;
            rx      <= 7'd0;
        end else begin
            if (ncs_s || state == S_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (rise) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (rise) begin
                rx <= rx_byte[6:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (ncs_s) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (ncs_fall) state_nxt = S_CMD;
                S_CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_READ) begin
                            state_nxt = S_ADDR;
`ifdef ADXL_RESP_WRITE_EN
                        end else if (rx_byte == CMD_WRITE) begin
                            state_nxt = S_ADDR;
`endif
                        end else begin
                            state_nxt = S_IGNORE;
                        end
                    end
                end
                S_ADDR: if (byte_done) state_nxt = op_write ? S_WRITE : S_READ;
                default: state_nxt = state;
            endcase
        end
    end

    assign miso_oe = (state == S_READ);
    assign miso_o  = (state == S_READ) & shift[7];

    // Every byte load is followed by one fall that must keep the MSB on the wire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            shift     <= 8'h00;
            skip_fall <= 1'b0;
            op_write  <= 1'b0;
        end else begin
`ifdef ADXL_RESP_WRITE_EN
            if (state == S_CMD && byte_done) begin
                op_write <= (rx_byte == CMD_WRITE);
            end
`endif
            if (state == S_ADDR && byte_done) begin
                ptr       <= rx_byte[ADDR_W-1:0];
                shift     <= regs[rx_byte[ADDR_W-1:0]];
                skip_fall <= 1'b1;
            end else if (state == S_READ) begin
                if (byte_done) begin
                    ptr       <= ptr_inc;
                    shift     <= regs[ptr_inc];
                    skip_fall <= 1'b1;
                end else if (fall) begin
                    if (skip_fall) begin
                        skip_fall <= 1'b0;
                    end else begin
                        shift <= {shift[6:0], 1'b0};
                    end
                end
            end else if (state == S_WRITE && byte_done) begin
                ptr <= ptr_inc;
            end
        end
    end

    // Local load is applied last so it wins over a same-cycle SPI write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= reset_val(i);
            end
        end else begin
`ifdef ADXL_RESP_WRITE_EN
            if (state == S_WRITE && byte_done && ptr > ADDR_W'(2)) begin
                regs[ptr] <= rx_byte;
            end
`endif
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
        end
    end

`ifdef ADXL_RESP_WRITE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
        end else begin
            wr_stb <= (state == S_WRITE) && byte_done;
            if (state == S_WRITE && byte_done) begin
                wr_addr <= ptr;
                wr_data <= rx_byte;
            end
        end
    end
`else
    assign wr_stb  = 1'b0;
    assign wr_addr = '0;
    assign wr_data = 8'h00;
`endif

endmodule

// File: tb/tb_adxl_spi_responder.sv
// tb/tb_adxl_spi_responder.sv - directed bench for adxl_spi_responder with register-file model
module tb_adxl_spi_responder;
    localparam int AW = 6;
`ifdef ADXL_RESP_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sclk_i = 1'b0;
    logic          mosi_i = 1'b0;
    logic          ncs_i = 1'b1;
    logic          miso_o, miso_oe;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_data = 8'h00;
    logic          wr_stb;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;

    adxl_spi_responder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .sclk_i(sclk_i), .mosi_i(mosi_i), .ncs_i(ncs_i),
        .miso_o(miso_o), .miso_oe(miso_oe), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] mem_m [64];
    logic [7:0] txd [4];
    logic [7:0] rd_got [4];
    logic [1:0] ncs_hist;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
        mem_m[0] = 8'hAD;
        mem_m[1] = 8'h1D;
        mem_m[2] = 8'hF2;
    endtask

    // busy is the chip select as seen two clock edges earlier
    always @(posedge clk or posedge rst) begin
        if (rst) ncs_hist <= 2'b11;
        else     ncs_hist <= {ncs_hist[0], ncs_i};
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, ~ncs_hist[1]});
        if (wr_stb) begin
            if (wr_q.size() == 0) begin
                chk("wr_stb_unexpected", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_addr", {26'd0, wr_addr}, {26'd0, e.a});
                chk("wr_data", {24'd0, wr_data}, {24'd0, e.d});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int nb, output logic [7:0] r,
                             output bit oe_and, output bit oe_or);
        r = 8'h00;
        oe_and = 1'b1;
        oe_or = 1'b0;
        for (int i = 7; i > 7 - nb; i--) begin
            mosi_i = b[i];
            #80;
            r[i] = miso_o;
            oe_and = oe_and & miso_oe;
            oe_or = oe_or | miso_oe;
            sclk_i = 1'b1;
            #80;
            sclk_i = 1'b0;
        end
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input int ndata);
        logic [7:0] exp_rd [4];
        logic [7:0] r;
        logic [AW-1:0] a;
        bit is_rd, is_wr, oa, oo;
        is_rd = (cmd == 8'h0B);
        is_wr = WR_EN && (cmd == 8'h0A);
        for (int k = 0; k < ndata; k++) begin
            a = AW'(addr + k);
            exp_rd[k] = mem_m[a];
            if (is_wr) begin
                wr_q.push_back('{a: a, d: txd[k]});
                if (a > 2) mem_m[a] = txd[k];
            end
        end
        ncs_i = 1'b0;
        #80;
        send_byte(cmd, 8, r, oa, oo);
        chk("oe_cmd", {31'd0, oo}, 32'd0);
        send_byte(addr, 8, r, oa, oo);
        chk("oe_addr", {31'd0, oo}, 32'd0);
        for (int k = 0; k < ndata; k++) begin
            send_byte(txd[k], 8, r, oa, oo);
            rd_got[k] = r;
            if (is_rd) begin
                chk("rd_data", {24'd0, r}, {24'd0, exp_rd[k]});
                chk("oe_data", {31'd0, oa}, 32'd1);
            end else begin
                chk("oe_nodata", {31'd0, oo}, 32'd0);
            end
        end
        #80;
        ncs_i = 1'b1;
        #240;
        chk("wr_pending", wr_q.size(), 32'd0);
        chk("oe_after", {31'd0, miso_oe}, 32'd0);
    endtask

    task automatic local_load(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        mem_m[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        bit oa, oo;
        model_reset();
        txd = '{8'h00, 8'h00, 8'h00, 8'h00};
        #40;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_miso", {31'd0, miso_o}, 32'd0);
        chk("rst_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
        chk("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);

        run_txn(8'h0B, 8'h00, 3);
        chk("id0", {24'd0, rd_got[0]}, 32'hAD);
        chk("id1", {24'd0, rd_got[1]}, 32'h1D);
        chk("id2", {24'd0, rd_got[2]}, 32'hF2);

        local_load(6'h0E, 8'h5A);
        run_txn(8'h0B, 8'h0E, 2);
        chk("xdata", {24'd0, rd_got[0]}, 32'h5A);
        chk("xdata_next", {24'd0, rd_got[1]}, 32'h00);

        txd = '{8'h02, 8'h07, 8'h00, 8'h00};
        run_txn(8'h0A, 8'h2D, 2);
        txd = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_txn(8'h0B, 8'h2D, 2);
`ifdef ADXL_RESP_WRITE_EN
        chk("wb0", {24'd0, rd_got[0]}, 32'h02);
        chk("wb1", {24'd0, rd_got[1]}, 32'h07);
`else
        chk("wb0_ro", {24'd0, rd_got[0]}, 32'h00);
`endif

        txd = '{8'h55, 8'h00, 8'h00, 8'h00};
        run_txn(8'h0A, 8'h00, 1);
        txd = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_txn(8'h0B, 8'h00, 1);
        chk("ro_reg0", {24'd0, rd_got[0]}, 32'hAD);

        run_txn(8'h0D, 8'h00, 1);

        // write aborted after four data bits
        if (WR_EN) begin
            ncs_i = 1'b0;
            #80;
            send_byte(8'h0A, 8, r, oa, oo);
            send_byte(8'h30, 8, r, oa, oo);
            send_byte(8'hFF, 4, r, oa, oo);
            #80;
            ncs_i = 1'b1;
            #240;
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_oe", {31'd0, miso_oe}, 32'd0);
        end
        run_txn(8'h0B, 8'h30, 1);
        chk("abort_reg", {24'd0, rd_got[0]}, 32'h00);

        local_load(6'h3F, 8'hC3);
        run_txn(8'h0B, 8'h3F, 2);
        chk("wrap0", {24'd0, rd_got[0]}, 32'hC3);
        chk("wrap1", {24'd0, rd_got[1]}, 32'hAD);

        // reset in the middle of a data byte
        ncs_i = 1'b0;
        #80;
        send_byte(8'h0B, 8, r, oa, oo);
        send_byte(8'h00, 8, r, oa, oo);
        send_byte(8'h00, 3, r, oa, oo);
        #40;
        chk("pre_rst_oe", {31'd0, miso_oe}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_miso", {31'd0, miso_o}, 32'd0);
        ncs_i = 1'b1;
        sclk_i = 1'b0;
        mosi_i = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(8'h0B, 8'h0E, 1);
        chk("rst_restore", {24'd0, rd_got[0]}, 32'h00);
        run_txn(8'h0B, 8'h3F, 1);
        chk("rst_restore_3f", {24'd0, rd_got[0]}, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adxl_spi_responder.md
# adxl_spi_responder

SPI mode-0 responder that models the accelerometer side of the PmodACL2 link, so the SPI read sequencer (command 0x0B, address, data) can be exercised end-to-end in simulation and on the FPGA loopback build. It oversamples SCLK, MOSI and nCS in the system clock domain and decodes read (0x0B) and write (0x0A) transactions. Transactions access an internal byte register file with address auto-increment. A local load port lets the rest of the design refresh sample registers such as XDATA at 0x0E.

## Interface
- ADDR_W, 6: register file address width (2^ADDR_W bytes).
- clk  in  1  system clock; must be ≥8× SCLK frequency.
- rst  in  1  reset, asynchronous, active-high.
- sclk_i  in  1  SPI clock from master, idle low.
- mosi_i  in  1  master-out data.
- ncs_i  in  1  chip select, active-low.
- miso_o  out  1  responder data.
- miso_oe  out  1  high while responder drives MISO (READ state only).
- ld_en  in  1  local register load strobe.
- ld_addr  in  ADDR_W  local load address.
- ld_data  in  8  local load data.
- wr_stb  out  1  one-cycle pulse per completed SPI write byte.
- wr_addr  out  ADDR_W  address of that byte.
- wr_data  out  8  data of that byte.
- busy  out  1  synchronized nCS asserted.

## Operation
- Input sync: 2-flop synchronizers on sclk_i, mosi_i and ncs_i, then one extra register for edge detect.
  - rise = SCLK rising, used to sample MOSI.
  - fall = SCLK falling, used to shift MISO.
  - All decode uses synchronized signals only.
- Reset values: 0x00=0xAD, 0x01=0x1D, 0x02=0xF2, all other registers 0x00. State IDLE, miso_o=0, miso_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0.
- Registers 0x00–0x02 are read-only to SPI; the local load port can write any address.
- Bit counter 0–7 counts rise events, MSB first. A byte completes on the 8th rise.
- States:
  - IDLE: on nCS fall → CMD; clear bit counter.
  - CMD: on byte complete:
    - 0x0B → ADDR with op=read.
    - 0x0A → ADDR with op=write.
    - any other value → IGNORE.
  - ADDR: on byte complete, latch pointer.
    - If op=read: load shift register with reg[pointer] → READ.
    - If op=write: → WRITE.
  - READ:
    - miso_o = shift register MSB; shift left on each fall, except the fall immediately after the address byte, which presents the MSB.
    - On byte complete: pointer+1, reload shift register from reg[pointer+1].
  - WRITE:
    - On byte complete: if pointer > 2, write reg[pointer]; pulse wr_stb with wr_addr/wr_data regardless; pointer+1.
  - IGNORE: MOSI discarded, miso_oe=0.
- Any state: synchronized nCS high → IDLE next cycle. Partial byte discarded, no write, miso_oe=0.
- Pointer wraps modulo 2^ADDR_W (0x3F → 0x00).
- Read data is snapshotted at byte load; later register changes do not affect the in-flight byte.
- Simultaneous ld_en and SPI write to the same address in the same cycle: ld_data wins. wr_stb still pulses.
- busy = synchronized ~nCS.

## Timing
- MOSI sampled 3 clk cycles after the physical SCLK rise (2 sync + 1 edge).
- miso_o changes ≤4 clk cycles after the physical SCLK fall. With clk ≥8× SCLK this meets mode-0 setup to the next rise.
- First read-data MSB is valid within 4 clk cycles after the SCLK fall following the 8th address bit.
- wr_stb is asserted the cycle after the 8th rise of a data byte. The register is updated in the same cycle.
- miso_oe asserts with the first READ-state bit. It deasserts ≤4 cycles after nCS rises.
- Asynchronous reset mid-transaction: all state returns to reset values immediately; the register file is restored to defaults.
- ld_en writes take effect the next cycle and are visible to the next byte load.

## Configuration
- ADXL_RESP_WRITE_EN
  - Defined: 0x0A write transactions are supported as above.
  - Undefined: 0x0A decodes as unknown → IGNORE; wr_stb is tied 0; only the local load port modifies registers.

## Test plan
- Reset, then read 0x0B,0x00 plus 3 bytes → MISO returns 0xAD, 0x1D, 0xF2; miso_oe high only during the data bytes.
- ld_en addr 0x0E data 0x5A, then read 0x0B,0x0E plus 2 bytes → 0x5A, 0x00.
- Write (macro defined) 0x0A,0x2D,0x02,0x07 → wr_stb pulses twice (0x2D/0x02, 0x2E/0x07); read back gives 0x02, 0x07.
- Write 0x0A,0x00,0x55 → wr_stb pulses with 0x00/0x55; subsequent read of 0x00 still returns 0xAD.
- Command 0x0D followed by 16 clocks → miso_oe stays 0; no wr_stb. nCS raised after 4 bits of a write data byte → no wr_stb; state IDLE.
- Read starting at 0x3F for 2 bytes → reg[0x3F], then 0xAD (wrap). Assert rst mid-byte → miso_oe=0, busy=0, state IDLE.
